// File: rtl/fxp_pkg.sv
// Shared encodings and helpers for the fixed-point lane multiplier.
package fxp_pkg;

    // Rounding modes for the ROUND parameter
    localparam int RND_TRUNC   = 0;
    localparam int RND_HALF_UP = 1;

    // Overflow handling modes for the SAT parameter
    localparam int SAT_WRAP  = 0;
    localparam int SAT_CLAMP = 1;

    // Fractional bits of a signed Q1.(const_w-1) coefficient
    function automatic int frac_bits(input int const_w);
        return const_w - 1;
    endfunction

endpackage

// File: rtl/fxp_mul_lane.sv
// One combinational lane: full-precision signed multiply, optional
// round-half-up, arithmetic shift by FRAC, then wrap or clamp to IN_W bits.
module fxp_mul_lane
    import fxp_pkg::*;
#(
    parameter int IN_W    = 32,
    parameter int CONST_W = 16,
    parameter int ROUND   = RND_HALF_UP,
    parameter int SAT     = SAT_CLAMP
) (
    input  logic signed [IN_W-1:0]    a,
    input  logic signed [CONST_W-1:0] b,
    output logic signed [IN_W-1:0]    result,
    output logic                      ovf
);

    localparam int FRAC = frac_bits(CONST_W);
    localparam int PW   = IN_W + CONST_W;
    // One spare bit so adding the rounding bias can never wrap
    localparam int EW   = PW + 1;

    localparam logic signed [EW-1:0] BIAS =
        (ROUND == RND_HALF_UP && FRAC > 0) ? (EW'(1) <<< ((FRAC > 0) ? FRAC - 1 : 0)) : '0;
    localparam logic signed [EW-1:0] MAXV = (EW'(1) <<< (IN_W - 1)) - EW'(1);
    localparam logic signed [EW-1:0] MINV = -(EW'(1) <<< (IN_W - 1));

    logic signed [PW-1:0] prod;
    logic signed [EW-1:0] shifted;

    function automatic logic signed [EW-1:0] round_shift(input logic signed [PW-1:0] p);
        logic signed [EW-1:0] t;
        t = EW'(p) + BIAS;
        return t >>> FRAC;
    endfunction

    function automatic logic out_of_range(input logic signed [EW-1:0] v);
        return (v > MAXV) || (v < MINV);
    endfunction

    function automatic logic signed [IN_W-1:0] saturate(input logic signed [EW-1:0] v);
        if (SAT == SAT_CLAMP && v > MAXV) return MAXV[IN_W-1:0];
        if (SAT == SAT_CLAMP && v < MINV) return MINV[IN_W-1:0];
        return v[IN_W-1:0];
    endfunction

    // Multiply, scale back to the data format and resolve overflow
    always_comb begin
        prod    = PW'(a) * PW'(b);
        shifted = round_shift(prod);
        ovf     = out_of_range(shifted);
        result  = saturate(shifted);
    end

endmodule

// File: rtl/fxp_mul_pipe.sv
// LANES-wide fixed-point multiplier with an elastic LAT-stage pipeline.
// Lane arithmetic sits in front of stage 0; later stages only carry results.
// LAT is meant to be 1..4.
module fxp_mul_pipe
    import fxp_pkg::*;
#(
    parameter int IN_W    = 32,
    parameter int CONST_W = 16,
    parameter int LANES   = 8,
    parameter int LAT     = 2,
    parameter int ROUND   = RND_HALF_UP,
    parameter int SAT     = SAT_CLAMP
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic signed [LANES-1:0][IN_W-1:0]    in_a,
    input  logic signed [LANES-1:0][CONST_W-1:0] in_b,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic signed [LANES-1:0][IN_W-1:0]    out_result,
    output logic        [LANES-1:0]              out_ovf
);

    localparam int MID = (LAT > 1) ? LAT - 1 : 1;

    logic signed [LANES-1:0][IN_W-1:0] lane_res;
    logic        [LANES-1:0]           lane_ovf;

    logic [LAT-1:0] vld_p;
    logic [LAT-1:0] up_vld;
    logic [LAT-1:0] rdy;

    logic signed [LANES-1:0][IN_W-1:0] res_mid [MID];
    logic        [LANES-1:0]           ovf_mid [MID];

    logic signed [LANES-1:0][IN_W-1:0] last_src_res;
    logic        [LANES-1:0]           last_src_ovf;
    logic                              last_src_vld;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        fxp_mul_lane #(
            .IN_W    (IN_W),
            .CONST_W (CONST_W),
            .ROUND   (ROUND),
            .SAT     (SAT)
        ) u_lane (
            .a      (in_a[i]),
            .b      (in_b[i]),
            .result (lane_res[i]),
            .ovf    (lane_ovf[i])
        );
    end

    // Each stage's valid comes from the stage upstream; stage 0 from in_valid
    assign up_vld = LAT'({vld_p, in_valid});

    // A stage may load if it or any stage downstream has a hole, or the output drains
    always_comb begin : p_ready
        logic chain;
        rdy   = '0;
        chain = out_ready;
        for (int s = LAT - 1; s >= 0; s--) begin
            chain  = chain || !vld_p[s];
            rdy[s] = chain;
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = vld_p[LAT-1];

    // Stage valid bits: the only state cleared by reset besides the output beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p <= '0;
        end else begin
            for (int s = 0; s < LAT; s++) begin
                if (rdy[s]) vld_p[s] <= up_vld[s];
            end
        end
    end

    // ---- stage boundary: lanes -> stage 0 .. stage LAT-2 (unreset data) ----
    for (genvar s = 0; s < LAT - 1; s++) begin : g_mid
        if (s == 0) begin : g_first
            // Capture lane results when stage 0 loads a real beat
            always_ff @(posedge clk) begin
                if (rdy[0] && in_valid) begin
                    res_mid[0] <= lane_res;
                    ovf_mid[0] <= lane_ovf;
                end
            end
        end else begin : g_next
            // Shift a real beat forward; empty stages keep their old data
            always_ff @(posedge clk) begin
                if (rdy[s] && vld_p[s-1]) begin
                    res_mid[s] <= res_mid[s-1];
                    ovf_mid[s] <= ovf_mid[s-1];
                end
            end
        end
    end

    if (LAT == 1) begin : g_src_lane
        assign last_src_res = lane_res;
        assign last_src_ovf = lane_ovf;
        assign last_src_vld = in_valid;
    end else begin : g_src_mid
        assign last_src_res = res_mid[LAT-2];
        assign last_src_ovf = ovf_mid[LAT-2];
        assign last_src_vld = vld_p[LAT-2];
    end

    // ---- stage boundary: final stage drives the outputs, held while stalled ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_result <= '0;
            out_ovf    <= '0;
        end else if (rdy[LAT-1] && last_src_vld) begin
            out_result <= last_src_res;
            out_ovf    <= last_src_ovf;
        end
    end

endmodule

// File: doc/fxp_mul_pipe.md
FXP_MUL_PIPE -- requirements
Module: fxp_mul_pipe

Interface
REQ-001 The block SHALL have parameter IN_W, default 32, meaning signed data width per lane.
REQ-002 The block SHALL have parameter CONST_W, default 16, meaning signed Q1.(CONST_W-1) coefficient width; FRAC = CONST_W-1.
REQ-003 The block SHALL have parameter LANES, default 8, meaning parallel multiply lanes, one DCT row.
REQ-004 The block SHALL have parameter LAT, default 2, legal range 1..4, meaning pipeline stages from accept to output.
REQ-005 The block SHALL have parameter ROUND, default 1, meaning 0 = truncate and 1 = round-half-up.
REQ-006 The block SHALL have parameter SAT, default 1, meaning 0 = wrap and 1 = saturate to the signed IN_W range.
REQ-007 The block SHALL have port clk, input, 1 bit, meaning the single clock.
REQ-008 The block SHALL have port rst_n, input, 1 bit, meaning asynchronous active-low reset.
REQ-009 The block SHALL have port in_valid, input, 1 bit, meaning the input beat is valid.
REQ-010 The block SHALL have port in_ready, output, 1 bit, meaning the block accepts the beat this cycle.
REQ-011 The block SHALL have port in_a, input, LANES x IN_W signed, meaning data per lane.
REQ-012 The block SHALL have port in_b, input, LANES x CONST_W signed, meaning coefficient per lane.
REQ-013 The block SHALL have port out_valid, output, 1 bit, meaning the result beat is valid.
REQ-014 The block SHALL have port out_ready, input, 1 bit, meaning the downstream accepts the beat.
REQ-015 The block SHALL have port out_result, output, LANES x IN_W signed, meaning the product per lane.
REQ-016 The block SHALL have port out_ovf, output, LANES bits, meaning per-lane overflow flag for this beat.

Function
REQ-017 Each lane SHALL compute p = a*b at full precision (IN_W+CONST_W bits, signed).
REQ-018 With ROUND=1, each lane SHALL add 2^(FRAC-1) to p before an arithmetic right shift by FRAC; with ROUND=0 it SHALL shift only (floor).
REQ-019 Overflow SHALL be flagged when the shifted value lies outside [-2^(IN_W-1), 2^(IN_W-1)-1].
REQ-020 On overflow, SAT=1 SHALL clamp to the nearest bound and SAT=0 SHALL keep the low IN_W bits; out_ovf SHALL be set in both modes.
REQ-021 A beat SHALL be accepted when in_valid && in_ready, and delivered when out_valid && out_ready.
REQ-022 With out_ready held high, a result SHALL appear exactly LAT cycles after acceptance, and throughput SHALL be 1 beat per cycle.
REQ-023 The pipeline SHALL be elastic per stage: a stage loads when it is empty or its contents advance the same cycle.
REQ-024 in_ready SHALL equal (stage 0 empty) OR (stage 0 advancing), with no combinational path from in_valid to in_ready.
REQ-025 While out_valid=1 and out_ready=0, out_result and out_ovf SHALL be held stable.
REQ-026 Up to LAT beats SHALL be buffered under backpressure, and no beat SHALL be lost or duplicated.
REQ-027 Accept and deliver in the same cycle on a full pipeline SHALL be sustained without a bubble.
REQ-028 Beats SHALL leave in acceptance order.
REQ-029 Data registers of empty stages SHALL hold their contents; only valid bits gate the output.

Reset
REQ-030 rst_n low SHALL asynchronously clear all stage valid bits, out_valid, out_result and out_ovf to 0.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight beats.
REQ-032 in_ready SHALL read 1 in the first cycle after reset release.
REQ-033 Reset SHALL be released synchronously to clk by the system; the block adds no synchroniser.

Structure
REQ-034 Package fxp_pkg SHALL hold the ROUND and SAT encodings and a function computing FRAC from CONST_W.
REQ-035 Per-lane arithmetic SHALL be a combinational sub-module fxp_mul_lane, instantiated LANES times and placed before stage 0's register.
REQ-036 The remaining LAT-1 stages SHALL be result registers.

Verification
REQ-037 Scenario 1: a=100, b=16384 (0.5), IN_W=32, CONST_W=16 -> result 50, ovf 0, after LAT cycles.
REQ-038 Scenario 2: a=3, b=16384 -> result 1 with ROUND=0 and 2 with ROUND=1; a=-3 -> result -2 with ROUND=0 and -1 with ROUND=1.
REQ-039 Scenario 3: a=-2^31, b=-32768 -> SAT=1 gives 0x7FFFFFFF with ovf=1; SAT=0 gives 0x80000000 with ovf=1.
REQ-040 Scenario 4: stream 20 beats with out_ready toggling pseudo-randomly -> all 20 results in order and stable while stalled, with in_ready=0 only when the pipeline is full and stalled.
REQ-041 Scenario 5: full pipeline with out_ready=1 and continuous in_valid -> one beat per cycle and no bubbles.
REQ-042 Scenario 6: rst_n pulsed low with 2 beats in flight -> out_valid=0 immediately, and no stale beat after release.
